// File: rtl/instruction_issue_if.sv
// FIFO read-port and execution issue-port signals for instruction_issue.
// The master modport is the issue block's view; slave is the environment's view.
interface instruction_issue_if;
    logic        fifo_valid;
    logic [31:0] fifo_data;
    logic        fifo_pop;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic        issue_ready;

    modport master (
        input  fifo_valid, fifo_data, issue_ready,
        output fifo_pop, issue_valid, issue_instr
    );

    modport slave (
        output fifo_valid, fifo_data, issue_ready,
        input  fifo_pop, issue_valid, issue_instr
    );
endinterface

// File: rtl/instruction_issue.sv
// Pops a show-ahead instruction FIFO into a 2-entry skid buffer and issues over valid/ready.
// Fetching stops after a HALT opcode until resume; issue and stall counts are kept for the host.
module instruction_issue #(
    parameter logic [5:0] HALT_OPCODE = 6'h3F,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 resume,
    input  logic                 clr_stats,
    instruction_issue_if.master  bus,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] issued_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [31:0]          buf0_q, buf0_d;
    logic [31:0]          buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    logic pop;
    logic issue;
    logic is_halt_word;

    // Enable gates the pop so nothing is fetched on the edge that leaves RUN.
    assign pop          = (state_q == RUN) && enable && bus.fifo_valid && (cnt_q != 2'd2);
    assign issue        = (cnt_q != 2'd0) && bus.issue_ready;
    assign is_halt_word = (bus.fifo_data[31:26] == HALT_OPCODE);

    always_comb begin
        cnt_d  = cnt_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({pop, issue})
            2'b11: begin
                // A pop only happens with room, so cnt is 1 here: the new word becomes the head.
                buf0_d = bus.fifo_data;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    buf0_d = bus.fifo_data;
                end else begin
                    buf1_d = bus.fifo_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (pop && is_halt_word) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_d = enable ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (clr_stats) begin
            issued_d = '0;
            stall_d  = '0;
        end else begin
            if (issue) begin
                issued_d = issued_q + CNT_WIDTH'(1);
            end
            if ((cnt_q != 2'd0) && !bus.issue_ready && (stall_q != '1)) begin
                stall_d = stall_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            buf0_q   <= 32'h0;
            buf1_q   <= 32'h0;
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.fifo_pop    = pop;
    assign bus.issue_valid = (cnt_q != 2'd0);
    assign bus.issue_instr = buf0_q;
    assign halted          = (state_q == HALTED) && (cnt_q == 2'd0);
    assign issued_count    = issued_q;
    assign stall_count     = stall_q;

endmodule

// File: tb/tb_instruction_issue.sv
// Directed and randomized bench for instruction_issue against a queue-based behavioural model.
// Narrow counters are used so that wrap and saturation are reachable.
module tb_instruction_issue;

    localparam int          CW   = 5;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          resume;
    logic          clr_stats;
    logic          halted;
    logic [CW-1:0] issued_count;
    logic [CW-1:0] stall_count;

    instruction_issue_if bus_if ();

    instruction_issue #(
        .HALT_OPCODE (6'h3F),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .resume       (resume),
        .clr_stats    (clr_stats),
        .bus          (bus_if.master),
        .halted       (halted),
        .issued_count (issued_count),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: upstream FIFO contents, buffered instructions, and fetch/halt mode flags.
    logic [31:0] fifo_q[$];
    logic [31:0] buf_q[$];
    bit          fetching;
    bit          halt_mode;
    int unsigned m_issued;
    int unsigned m_stall;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        buf_q.delete();
        fetching  = 1'b0;
        halt_mode = 1'b0;
        m_issued  = 0;
        m_stall   = 0;
    endtask

    task automatic pushWord(input logic [31:0] w);
        fifo_q.push_back(w);
    endtask

    // One clock cycle: drive inputs, check settled outputs mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input bit en, input bit rdy, input bit res, input bit clr);
        bit          exp_pop;
        bit          exp_valid;
        bit          exp_issue;
        logic [31:0] w;
        enable              = en;
        bus_if.issue_ready  = rdy;
        resume              = res;
        clr_stats           = clr;
        bus_if.fifo_valid   = (fifo_q.size() > 0);
        bus_if.fifo_data    = (fifo_q.size() > 0) ? fifo_q[0] : $urandom();
        #1;
        exp_pop   = fetching && en && (fifo_q.size() > 0) && (buf_q.size() < 2);
        exp_valid = (buf_q.size() != 0);
        exp_issue = exp_valid && rdy;
        checkOutput("fifo_pop", {31'b0, bus_if.fifo_pop}, {31'b0, exp_pop});
        checkOutput("issue_valid", {31'b0, bus_if.issue_valid}, {31'b0, exp_valid});
        if (exp_valid) checkOutput("issue_instr", bus_if.issue_instr, buf_q[0]);
        checkOutput("halted", {31'b0, halted}, {31'b0, (halt_mode && buf_q.size() == 0)});
        checkOutput("issued_count", 32'(issued_count), m_issued);
        checkOutput("stall_count", 32'(stall_count), m_stall);
        @(posedge clk);
        if (exp_issue) begin
            void'(buf_q.pop_front());
            m_issued = (m_issued + 1) & CMAX;
        end
        if (exp_valid && !rdy && m_stall != CMAX) m_stall++;
        if (clr) begin
            m_issued = 0;
            m_stall  = 0;
        end
        if (halt_mode) begin
            if (res) begin
                halt_mode = 1'b0;
                fetching  = en;
            end
        end else if (fetching) begin
            if (!en) begin
                fetching = 1'b0;
            end else if (exp_pop) begin
                w = fifo_q.pop_front();
                buf_q.push_back(w);
                if (w[31:26] == 6'h3F) begin
                    fetching  = 1'b0;
                    halt_mode = 1'b1;
                end
            end
        end else if (en) begin
            fetching = 1'b1;
        end
        #2;
    endtask

    // Asynchronous reset away from any edge; outputs must clear before the next clock.
    task automatic doReset();
        enable = 1'b0;
        rst_n  = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_issue_valid", {31'b0, bus_if.issue_valid}, 32'h0);
        checkOutput("rst_issue_instr", bus_if.issue_instr, 32'h0);
        checkOutput("rst_fifo_pop", {31'b0, bus_if.fifo_pop}, 32'h0);
        checkOutput("rst_halted", {31'b0, halted}, 32'h0);
        checkOutput("rst_issued_count", 32'(issued_count), 32'h0);
        checkOutput("rst_stall_count", 32'(stall_count), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n              = 1'b0;
        enable             = 1'b1;
        resume             = 1'b0;
        clr_stats          = 1'b0;
        bus_if.issue_ready = 1'b1;
        bus_if.fifo_valid  = 1'b1;
        bus_if.fifo_data   = 32'h1000;
        modelReset();
        #12;
        doReset();

        $display("[TB] streaming four words with issue_ready high");
        for (int i = 0; i < 4; i++) pushWord(32'h1000 + i);
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] downstream stall then drain");
        applyStimulus(1, 1, 0, 1);
        for (int i = 0; i < 4; i++) pushWord(32'h1000 + i);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] halt and resume");
        pushWord(32'h2000);
        pushWord(32'hFC000000);
        pushWord(32'h2001);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] enable dropped mid-stream");
        for (int i = 0; i < 8; i++) pushWord(32'h3000 + i);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 15) == 0) pushWord({6'h3F, 26'($urandom())});
                else pushWord({6'($urandom_range(0, 62)), 26'($urandom())});
            end
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
        end

        $display("[TB] stall saturation with a full buffer, then reset mid-stream");
        doReset();
        fifo_q.delete();
        for (int i = 0; i < 4; i++) pushWord(32'h4000 + i);
        for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 0);
        doReset();

        $display("[TB] clear coincident with an issue handshake");
        for (int i = 0; i < 3; i++) pushWord(32'h5000 + i);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
